// File: rtl/adc_readout_arbiter.sv
// Round-robin readout scheduler: drains one full ADC capture FIFO at a time
// as a framed AXI-Stream burst (header word followed by BURST samples).
module adc_readout_arbiter #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int BURST = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_full,
  input  logic [NCH-1:0]    ch_empty,
  input  logic [NCH*DW-1:0] ch_dout,
  output logic [NCH-1:0]    ch_rd_en,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [3:0]        m_tuser,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [3:0]    LAST_CH  = 4'(NCH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

  typedef enum logic [1:0] {ARB, HEADER, STREAM} state_t;

  state_t        state;
  logic [3:0]    g;
  logic [3:0]    last_grant;
  logic [7:0]    seq;
  logic [CW-1:0] cnt;

  logic [3:0]    pick;
  logic          pick_ok;
  logic [DW-1:0] sel_dout;
  logic          sel_empty;
  logic [DW-1:0] hdr_word;
  logic          handshake;
  logic          at_last;

  // Search distance d=1..NCH upward from last_grant; the first full channel wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int d = 1; d <= NCH; d++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pick_ok && ch_full[c] && (c == (int'(last_grant) + d) % NCH)) begin
          pick    = 4'(c);
          pick_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_dout  = '0;
    sel_empty = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (4'(c) == g) begin
        sel_dout  = ch_dout[c*DW +: DW];
        sel_empty = ch_empty[c];
      end
    end
  end

  assign hdr_word  = DW'({4'hA, g, seq});
  assign at_last   = (cnt == LAST_CNT);
  assign handshake = m_tvalid & m_tready;

  // Valid is qualified by rstn so a reset cycle can never pop the FIFO.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    case (state)
      HEADER: begin
        m_tvalid = rstn;
        m_tdata  = hdr_word;
      end
      STREAM: begin
        m_tvalid = rstn & ~sel_empty;
        m_tdata  = sel_dout;
        m_tlast  = at_last & rstn & ~sel_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    ch_rd_en = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_rd_en[c] = (state == STREAM) && (4'(c) == g) && handshake;
    end
  end

  assign busy    = (state != ARB);
  assign m_tuser = (state != ARB) ? g : 4'd0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ARB;
      last_grant <= LAST_CH;
      seq        <= 8'd0;
      cnt        <= '0;
      g          <= 4'd0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (enable && pick_ok) begin
            g     <= pick;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (handshake) state <= STREAM;
        end
        STREAM: begin
          if (sel_empty) underrun <= 1'b1;
          if (handshake) begin
            if (at_last) begin
              last_grant <= g;
              seq        <= seq + 8'd1;
              cnt        <= '0;
              state      <= ARB;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
